// File: rtl/seq_shift_unit.sv
// Multi-cycle 16-bit shift/rotate unit: one single-bit step per clock under a
// start/busy/done handshake, bit-identical to the combinational Shifter/Rotator.
module seq_shift_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] in,
  input  logic [3:0]  shift,
  input  logic        lr,
  input  logic        rot,
  output logic        busy,
  output logic        done,
  output logic [15:0] out
);

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CNTW  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  work_q, work_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              lr_q, lr_d;
  logic              rot_q, rot_d;
  logic [WIDTH-1:0]  out_d;
  logic              busy_d;
  logic              done_d;
  logic [WIDTH-1:0]  step_c;

  // One-bit step of the captured operand; fill is the wrapped bit only when rotating.
  always_comb begin
    if (lr_q) begin
      step_c = {rot_q & work_q[0], work_q[WIDTH-1:1]};
    end else begin
      step_c = {work_q[WIDTH-2:0], rot_q & work_q[WIDTH-1]};
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    lr_d    = lr_q;
    rot_d   = rot_q;
    out_d   = out;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          work_d = in;
          cnt_d  = shift;
          lr_d   = lr;
          rot_d  = rot;
          if (shift == CNTW'(0)) begin
            out_d   = in;
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_d = step_c;
        cnt_d  = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) begin
          out_d   = step_c;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshake flags are registered copies of the upcoming state.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      lr_q    <= 1'b0;
      rot_q   <= 1'b0;
      out     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      lr_q    <= lr_d;
      rot_q   <= rot_d;
      out     <= out_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Directed bench for seq_shift_unit: table of hand-computed vectors plus
// sequences for ignored starts and mid-operation reset.
module tb_seq_shift_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] in;
  logic [3:0]  shift;
  logic        lr;
  logic        rot;
  logic        busy;
  logic        done;
  logic [15:0] out;

  int n_cmp = 0;
  int n_err = 0;

  seq_shift_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .in    (in),
    .shift (shift),
    .lr    (lr),
    .rot   (rot),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] din;
    logic [3:0]  n;
    logic        lr;
    logic        rot;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Independent combinational reference for the Shifter/Rotator.
  function automatic logic [15:0] ref_model(input logic [15:0] d, input logic [3:0] n,
                                            input logic dir, input logic r);
    logic [31:0] t;
    if (!r) begin
      ref_model = dir ? (d >> n) : (d << n);
    end else if (!dir) begin
      t = {d, d} << n;
      ref_model = t[31:16];
    end else begin
      t = {d, d} >> n;
      ref_model = t[15:0];
    end
  endfunction

  // Accept one op, then check busy/done timing and out on every cycle until IDLE.
  task automatic run_op(input logic [15:0] d, input logic [3:0] n, input logic dir,
                        input logic r, input logic [15:0] exp, input string name);
    logic [15:0] prev;
    @(negedge clk);
    prev  = out;
    start = 1'b1;
    in    = d;
    shift = n;
    lr    = dir;
    rot   = r;
    @(posedge clk);
    #1;
    start = 1'b0;
    in    = 16'hDEAD;
    shift = 4'd7;
    lr    = ~dir;
    rot   = ~r;
    for (int k = 0; k <= int'(n); k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      check({name, ".busy"}, 16'(busy), 16'd1);
      check({name, ".done"}, 16'(done), (k == int'(n)) ? 16'd1 : 16'd0);
      if (k < int'(n)) check({name, ".out_hold"}, out, prev);
    end
    check({name, ".out"}, out, exp);
    check({name, ".model"}, out, ref_model(d, n, dir, r));
    @(posedge clk);
    #1;
    check({name, ".busy_end"}, 16'(busy), 16'd0);
    check({name, ".done_end"}, 16'(done), 16'd0);
    check({name, ".out_end"}, out, exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;

    vecs[0]  = '{16'h4A63, 4'd4,  1'b0, 1'b0, 16'hA630};
    vecs[1]  = '{16'h4A63, 4'd8,  1'b0, 1'b0, 16'h6300};
    vecs[2]  = '{16'h4A63, 4'd4,  1'b1, 1'b0, 16'h04A6};
    vecs[3]  = '{16'h4A63, 4'd8,  1'b1, 1'b0, 16'h004A};
    vecs[4]  = '{16'h4A63, 4'd4,  1'b0, 1'b1, 16'hA634};
    vecs[5]  = '{16'h4A63, 4'd4,  1'b1, 1'b1, 16'h34A6};
    vecs[6]  = '{16'h4A63, 4'd8,  1'b0, 1'b1, 16'h634A};
    vecs[7]  = '{16'h4A63, 4'd15, 1'b1, 1'b1, 16'h94C6};
    vecs[8]  = '{16'h4A63, 4'd0,  1'b0, 1'b0, 16'h4A63};
    vecs[9]  = '{16'h4A63, 4'd15, 1'b0, 1'b0, 16'h8000};
    vecs[10] = '{16'h4A63, 4'd15, 1'b1, 1'b0, 16'h0000};
    vecs[11] = '{16'h8001, 4'd15, 1'b1, 1'b0, 16'h0001};
    vecs[12] = '{16'h8001, 4'd1,  1'b0, 1'b1, 16'h0003};
    vecs[13] = '{16'h1234, 4'd0,  1'b1, 1'b1, 16'h1234};

    // Reset with start held high: nothing may start.
    rst_n = 1'b0;
    start = 1'b1;
    in    = 16'hFFFF;
    shift = 4'd0;
    lr    = 1'b0;
    rot   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("rst.busy", 16'(busy), 16'd0);
      check("rst.done", 16'(done), 16'd0);
      check("rst.out", out, 16'h0000);
    end
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_rel.busy", 16'(busy), 16'd0);
    check("rst_rel.out", out, 16'h0000);

    foreach (vecs[i]) begin
      run_op(vecs[i].din, vecs[i].n, vecs[i].lr, vecs[i].rot, vecs[i].exp,
             $sformatf("vec%0d", i));
    end

    // Ignored start during SHIFT (edge E+4) and DONE (edge E+9).
    @(negedge clk);
    start = 1'b1; in = 16'h4A63; shift = 4'd8; lr = 1'b0; rot = 1'b0;
    @(posedge clk);
    #1;
    dones = 0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      start = (k == 4 || k == 9);
      in = 16'hFFFF; shift = 4'd3; lr = 1'b1; rot = 1'b1;
      @(posedge clk);
      #1;
      if (done) dones++;
      check($sformatf("ign.busy%0d", k), 16'(busy), (k <= 8) ? 16'd1 : 16'd0);
    end
    check("ign.out", out, 16'h6300);
    check("ign.dones", 16'(dones), 16'd1);
    run_op(16'h4A63, 4'd4, 1'b1, 1'b1, 16'h34A6, "ign.next");

    // Reset mid-operation at edge E+5 of an N=12 op.
    @(negedge clk);
    start = 1'b1; in = 16'h4A63; shift = 4'd12; lr = 1'b0; rot = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst.busy", 16'(busy), 16'd0);
    check("midrst.done", 16'(done), 16'd0);
    check("midrst.out", out, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) dones++;
    end
    check("midrst.quiet", 16'(dones), 16'd0);
    run_op(16'h4A63, 4'd12, 1'b0, 1'b1, 16'h34A6, "midrst.next");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
